// File: rtl/v810_pkg.sv
// ----------------------------------------------------------------------------
// v810_pkg
// Shared types and helpers for the v810 instruction prefetch queue.
//   addr_t      32-bit byte address
//   word_t      32-bit instruction word
//   pf_state_t  memory-fetch FSM state
//   hw_merge()  builds a halfword-misaligned 32-bit fetch from two words
// ----------------------------------------------------------------------------
package v810_pkg;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_FETCH,
        PF_DRAIN
    } pf_state_t;

    // A fetch at byte offset 2 takes the upper half of the lower word as its
    // low halfword and the lower half of the next word as its high halfword.
    function automatic word_t hw_merge(input word_t lo_word, input word_t hi_word);
        return {hi_word[15:0], lo_word[31:16]};
    endfunction

endpackage

// File: rtl/v810_prefetch_fifo.sv
// ----------------------------------------------------------------------------
// v810_prefetch_fifo
// DEPTH-word circular storage for the prefetch queue. The owner tracks the
// occupancy; this block only keeps the head pointer and the word array.
//   clk, rst_n   clock, asynchronous active-low reset (head pointer only)
//   wr_en        write wr_data at slot head+wr_off
//   wr_off       write offset from head (the current occupancy)
//   wr_data      word to store
//   pop          number of words to retire from the head (modulo DEPTH)
//   rd_off       read offset k from head
//   rd0, rd1     words at head+k and head+k+1
// ----------------------------------------------------------------------------
module v810_prefetch_fifo
    import v810_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_off,
    input  word_t         wr_data,
    input  logic [PW-1:0] pop,
    input  logic [PW-1:0] rd_off,
    output word_t         rd0,
    output word_t         rd1
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] wr_idx, rd_idx0, rd_idx1;
    word_t         mem_q [DEPTH];

    // DEPTH is a power of two, so all pointer arithmetic wraps naturally.
    always_comb begin
        head_d  = head_q + pop;
        wr_idx  = head_q + wr_off;
        rd_idx0 = head_q + rd_off;
        rd_idx1 = rd_idx0 + PW'(1);
    end

    assign rd0 = mem_q[rd_idx0];
    assign rd1 = mem_q[rd_idx1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
        end else begin
            head_q <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/v810_prefetch.sv
// ----------------------------------------------------------------------------
// v810_prefetch
// Instruction prefetch queue between the v810 execution unit fetch port and
// the memory EUI port. Fetches aligned words sequentially ahead of the
// execution unit, serves aligned and halfword-misaligned 32-bit fetches from
// the queue, and flushes/restarts on a request outside the queued window.
//   CLK, RESn, CE        clock, async active-low reset, clock enable
//   IA, IREQ             exec fetch address / request (held until IACK)
//   ID, IACK             fetch data / one-cycle acknowledge (registered)
//   MIA, MIREQ           memory word address / request (held until MIACK)
//   MID, MIACK           memory data / acknowledge
// Optional build macro V810_PREFETCH_STATS_EN adds saturating counters:
//   HITS                 number of IACK pulses
//   FLUSHES              number of out-of-window flushes
// ----------------------------------------------------------------------------
module v810_prefetch
    import v810_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic          CLK,
    input  logic          RESn,
    input  logic          CE,
    input  logic [AW-1:0] IA,
    input  logic          IREQ,
    output word_t         ID,
    output logic          IACK,
    output logic [AW-1:0] MIA,
    output logic          MIREQ,
    input  word_t         MID,
    input  logic          MIACK
`ifdef V810_PREFETCH_STATS_EN
    ,
    output logic [31:0]   HITS,
    output logic [31:0]   FLUSHES
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = AW - 2;   // addresses tracked as word addresses

    pf_state_t     state_q, state_d;
    logic [OW-1:0] ha_q, ha_d;
    logic [OW-1:0] mia_q, mia_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          iack_q, iack_d;
    word_t         id_q, id_d;

    logic [OW-1:0] w_word, ta_word, off;
    logic [CW-1:0] retire;
    logic          mis, hit, in_win, flush, fill;
    word_t         rd0, rd1;
    logic          ia_unused;

    assign ia_unused = IA[0];

    always_comb begin
        w_word  = IA[AW-1:2];
        mis     = IA[1];
        ta_word = ha_q + OW'(cnt_q);
        // Modular offset: a W below HA wraps to a huge value and misses.
        off     = w_word - ha_q;

        // The acknowledged request is still on IA during the IACK cycle, so
        // lookup is suppressed then to avoid acknowledging it twice.
        hit    = IREQ && !iack_q && (off < OW'(cnt_q)) &&
                 (!mis || (off + OW'(1) < OW'(cnt_q)));
        // W == TA counts as arriving soon, except when the queue is full: no
        // fetch can start then, so waiting would never complete.
        in_win = (off <= OW'(cnt_q)) && (cnt_q != CW'(DEPTH));
        flush  = IREQ && !iack_q && !hit && !in_win;
        fill   = (state_q == PF_FETCH) && MIACK && !flush;
        retire = hit ? (CW'(off) + CW'(mis)) : '0;

        if (flush) begin
            ha_d  = w_word;
            cnt_d = '0;
        end else begin
            ha_d  = ha_q + OW'(retire);
            cnt_d = cnt_q + CW'(fill) - retire;
        end

        iack_d = hit;
        id_d   = id_q;
        if (hit) begin
            id_d = mis ? hw_merge(rd0, rd1) : rd0;
        end

        state_d = state_q;
        mia_d   = mia_q;
        case (state_q)
            PF_IDLE: begin
                if (!flush && (cnt_q != CW'(DEPTH))) begin
                    state_d = PF_FETCH;
                    mia_d   = ta_word;
                end
            end
            PF_FETCH: begin
                // A flush coinciding with MIACK just drops the data (fill=0).
                if (MIACK) begin
                    state_d = PF_IDLE;
                end else if (flush) begin
                    state_d = PF_DRAIN;
                end
            end
            PF_DRAIN: begin
                if (MIACK) begin
                    state_d = PF_IDLE;
                end
            end
            default: state_d = PF_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q <= PF_IDLE;
            ha_q    <= '0;
            mia_q   <= '0;
            cnt_q   <= '0;
            iack_q  <= 1'b0;
            id_q    <= '0;
        end else if (CE) begin
            state_q <= state_d;
            ha_q    <= ha_d;
            mia_q   <= mia_d;
            cnt_q   <= cnt_d;
            iack_q  <= iack_d;
            id_q    <= id_d;
        end
    end

    v810_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RESn),
        .wr_en   (fill && CE),
        .wr_off  (cnt_q[PW-1:0]),
        .wr_data (MID),
        .pop     (CE ? retire[PW-1:0] : '0),
        .rd_off  (off[PW-1:0]),
        .rd0     (rd0),
        .rd1     (rd1)
    );

    assign MIREQ = (state_q != PF_IDLE);
    assign MIA   = {mia_q, 2'b00};
    assign IACK  = iack_q;
    assign ID    = id_q;

`ifdef V810_PREFETCH_STATS_EN
    logic [31:0] hits_q, hits_d, flushes_q, flushes_d;

    always_comb begin
        hits_d    = hits_q;
        flushes_d = flushes_q;
        if (iack_q && (hits_q != '1)) begin
            hits_d = hits_q + 32'd1;
        end
        if (flush && (flushes_q != '1)) begin
            flushes_d = flushes_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            hits_q    <= '0;
            flushes_q <= '0;
        end else if (CE) begin
            hits_q    <= hits_d;
            flushes_q <= flushes_d;
        end
    end

    assign HITS    = hits_q;
    assign FLUSHES = flushes_q;
`endif

endmodule

// File: tb/tb_v810_prefetch.sv
`timescale 1ns/1ps
module tb_v810_prefetch;
    import v810_pkg::*;

    logic        CLK = 1'b0;
    logic        RESn;
    logic        CE;
    logic [31:0] IA;
    logic        IREQ;
    word_t       ID;
    logic        IACK;
    logic [31:0] MIA;
    logic        MIREQ;
    word_t       MID;
    logic        MIACK;
`ifdef V810_PREFETCH_STATS_EN
    logic [31:0] HITS;
    logic [31:0] FLUSHES;
`endif

    int n_vec = 0;
    int n_err = 0;

    // memory model controls and log of every acknowledged fetch address
    int          mem_dly  = 1;
    int          pat_mode = 0;
    int          mcnt     = 0;
    logic [31:0] mia_log[$];

    always #5 CLK = ~CLK;

    v810_prefetch #(
        .DEPTH (4),
        .AW    (32)
    ) dut (
        .CLK   (CLK),
        .RESn  (RESn),
        .CE    (CE),
        .IA    (IA),
        .IREQ  (IREQ),
        .ID    (ID),
        .IACK  (IACK),
        .MIA   (MIA),
        .MIREQ (MIREQ),
        .MID   (MID),
        .MIACK (MIACK)
`ifdef V810_PREFETCH_STATS_EN
        ,
        .HITS    (HITS),
        .FLUSHES (FLUSHES)
`endif
    );

    a_iack_needs_ireq: assert property (@(posedge CLK) disable iff (!RESn) IACK |-> IREQ)
        else $error("IACK asserted without IREQ");
    a_ireq_held: assert property (@(posedge CLK) disable iff (!RESn) (IREQ && !IACK) |=> IREQ)
        else $error("IREQ dropped before IACK");

    function automatic word_t mem_word(input logic [31:0] a);
        if (pat_mode == 1 && a == 32'hFFF0_0000) return 32'h1111_2222;
        if (pat_mode == 1 && a == 32'hFFF0_0004) return 32'h3333_4444;
        return a;
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < 0 || i >= mia_log.size()) return 32'hDEAD_BEEF;
        return mia_log[i];
    endfunction

    // Memory responder: MIACK after mem_dly waiting cycles of MIREQ.
    initial begin
        MIACK = 1'b0;
        MID   = '0;
        forever begin
            @(posedge CLK or negedge RESn);
            #1;
            if (!RESn) begin
                MIACK = 1'b0;
                mcnt  = 0;
            end else if (MIACK) begin
                MIACK = 1'b0;
                mcnt  = 0;
            end else if (MIREQ) begin
                if (mcnt >= mem_dly) begin
                    MIACK = 1'b1;
                    MID   = mem_word(MIA);
                    mia_log.push_back(MIA);
                end else begin
                    mcnt++;
                end
            end
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Returns one cycle after the IACK cycle with IREQ still high on the old IA.
    task automatic fetch(input logic [31:0] a, output word_t data, output int lat);
        IA   = a;
        IREQ = 1'b1;
        lat  = 0;
        do begin
            @(posedge CLK);
            #1;
            lat++;
        end while (!IACK && lat < 200);
        data = ID;
        if (!IACK) begin
            n_vec++;
            n_err++;
            $display("FAIL fetch_timeout: no IACK for IA 0x%08h within %0d cycles", a, lat);
            IREQ = 1'b0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        IREQ = 1'b0;
        IA   = '0;
        RESn = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        mia_log.delete();
        RESn = 1'b1;
    endtask

    task automatic idle(input int n);
        IREQ = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t d;
        int    lat;
        logic [31:0] exp_a;

        CE   = 1'b1;
        IREQ = 1'b0;
        IA   = '0;
        RESn = 1'b1;
        #1 RESn = 1'b0;
        @(posedge CLK);
        #1;
        // reset state
        check_vec("rst_mireq", MIREQ, 0);
        check_vec("rst_iack", IACK, 0);
        check_vec("rst_id", ID, 0);
        check_vec("rst_mia", MIA, 0);
`ifdef V810_PREFETCH_STATS_EN
        check_vec("rst_hits", HITS, 0);
        check_vec("rst_flushes", FLUSHES, 0);
`endif

        // 1: sequential fetches from 0xFFF00000, MID = address
        do_reset();
        mem_dly  = 1;
        pat_mode = 0;
        fetch(32'hFFF0_0000, d, lat);
        check_vec("t1_id_first", d, 32'hFFF0_0000);
        check_vec("t1_first_waits_fill", 32'(lat > 1), 1);
        idle(20);
        check_vec("t1_full_mireq", MIREQ, 0);
        check_vec("t1_full_nfetch", mia_log.size(), 4);
        check_vec("t1_full_last_mia", log_at(mia_log.size() - 1), 32'hFFF0_000C);
        check_vec("t1_idle_iack", IACK, 0);
        for (int i = 1; i < 8; i++) begin
            exp_a = 32'hFFF0_0000 + 32'(4 * i);
            fetch(exp_a, d, lat);
            check_vec($sformatf("t1_id_%0d", i), d, exp_a);
            if (i <= 3) check_vec($sformatf("t1_lat_%0d", i), lat, 1);
        end
        IREQ = 1'b0;
`ifdef V810_PREFETCH_STATS_EN
        check_vec("t1_hits", HITS, 8);
        check_vec("t1_flushes", FLUSHES, 1);
`endif

        // 2: misaligned fetch spanning two words
        do_reset();
        pat_mode = 1;
        fetch(32'hFFF0_0002, d, lat);
        check_vec("t2_id_mis", d, 32'h4444_1111);
        idle(20);
        check_vec("t2_head_adv_last_mia", log_at(mia_log.size() - 1), 32'hFFF0_0010);
        fetch(32'hFFF0_0004, d, lat);
        check_vec("t2_id_next", d, 32'h3333_4444);
        check_vec("t2_lat_next", lat, 1);
        IREQ = 1'b0;
        pat_mode = 0;

        // 3: flush while the fetch of 0x10 is outstanding
        do_reset();
        mem_dly = 1;
        fetch(32'h0, d, lat);
        check_vec("t3_id0", d, 32'h0);
        idle(20);
        mem_dly = 3;
        fetch(32'h4, d, lat);
        check_vec("t3_id4", d, 32'h4);
        IREQ = 1'b0;
        for (int i = 0; i < 50 && !(MIREQ && MIA == 32'h10); i++) begin
            @(posedge CLK);
            #1;
        end
        check_vec("t3_fetch10_mireq", MIREQ, 1);
        check_vec("t3_fetch10_mia", MIA, 32'h10);
        fetch(32'h200, d, lat);
        check_vec("t3_id200", d, 32'h200);
        check_vec("t3_log_drained", log_at(4), 32'h10);
        check_vec("t3_log_restart", log_at(5), 32'h200);
        mem_dly = 1;
        fetch(32'h204, d, lat);
        check_vec("t3_id204", d, 32'h204);
        IREQ = 1'b0;

        // 4: full queue stalls fetching until the first retire
        do_reset();
        mem_dly = 1;
        idle(30);
        check_vec("t4_full_nfetch", mia_log.size(), 4);
        check_vec("t4_full_mireq", MIREQ, 0);
        fetch(32'h0, d, lat);
        check_vec("t4_id0", d, 32'h0);
        check_vec("t4_lat0", lat, 1);
        idle(10);
        check_vec("t4_no_retire_nfetch", mia_log.size(), 4);
        fetch(32'h4, d, lat);
        check_vec("t4_id4", d, 32'h4);
        idle(10);
        check_vec("t4_resume_nfetch", mia_log.size(), 5);
        check_vec("t4_resume_mia", log_at(4), 32'h10);

        // 5: fills every other cycle while the exec retires
        do_reset();
        mem_dly = 0;
        for (int i = 0; i < 8; i++) begin
            exp_a = 32'(4 * i);
            fetch(exp_a, d, lat);
            check_vec($sformatf("t5_id_%0d", i), d, exp_a);
        end
        idle(30);
        check_vec("t5_last_mia", log_at(mia_log.size() - 1), 32'h28);
        check_vec("t5_nfetch", mia_log.size(), 11);
`ifdef V810_PREFETCH_STATS_EN
        check_vec("t5_hits", HITS, 8);
`endif

        // address wrap at the top of the space
        do_reset();
        mem_dly = 1;
        fetch(32'hFFFF_FFFC, d, lat);
        check_vec("wrap_id_top", d, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFE, d, lat);
        check_vec("wrap_id_mis", d, 32'h0000_FFFF);
        fetch(32'h0, d, lat);
        check_vec("wrap_id_zero", d, 32'h0);
        IREQ = 1'b0;

        // 6: asynchronous reset in the middle of a fetch
        do_reset();
        mem_dly = 10;
        for (int i = 0; i < 20 && !MIREQ; i++) begin
            @(posedge CLK);
            #1;
        end
        check_vec("t6_mireq_before", MIREQ, 1);
        @(posedge CLK);
        #3;
        RESn = 1'b0;
        #1;
        check_vec("t6_mireq_async", MIREQ, 0);
        check_vec("t6_iack_async", IACK, 0);
        check_vec("t6_mia_async", MIA, 0);
`ifdef V810_PREFETCH_STATS_EN
        check_vec("t6_hits", HITS, 0);
        check_vec("t6_flushes", FLUSHES, 0);
`endif
        @(posedge CLK);
        #1;
        mem_dly = 1;
        RESn = 1'b1;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
